// File: rtl/ysyx_201979054_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the memory slave.
package ysyx_201979054_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/ysyx_201979054_beat_counter.sv
// Counts beats modulo BURST_LEN; o_done is a registered pulse one cycle after the wrapping beat.
// No backpressure: every i_beat cycle is counted.
module ysyx_201979054_beat_counter #(
    parameter int BURST_LEN = 16
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_beat,
    output logic o_done
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(BURST_LEN - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= i_beat && wrap;
            if (i_beat) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_201979054_axi_lite_mem_slave.sv
// AXI4-Lite word memory: R valid one cycle after AR, B valid one cycle after the later of AW/W.
// One outstanding transaction per direction; R/B payload held until the master takes it.
module ysyx_201979054_axi_lite_mem_slave
    import ysyx_201979054_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int BURST_LEN  = 16
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_rd_done,
    output logic                    o_wr_done
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- read path ----------------
    rd_state_e rd_state;
    logic      ar_hs;

    assign o_arready = (rd_state == R_IDLE);
    assign o_rvalid  = (rd_state == R_DATA);
    assign ar_hs     = o_arready && i_arvalid;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rd_state <= R_IDLE;
            o_rdata  <= '0;
            o_rresp  <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: if (ar_hs) begin
                    o_rdata  <= in_range(i_araddr) ? mem[word_idx(i_araddr)] : '0;
                    o_rresp  <= in_range(i_araddr) ? RESP_OKAY : RESP_SLVERR;
                    rd_state <= R_DATA;
                end
                R_DATA: if (i_rready) begin
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    wr_state_e             wr_state;
    logic                  aw_got, w_got;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_W-1:0]     cm_strb;

    assign o_awready = (wr_state == W_IDLE) && !aw_got;
    assign o_wready  = (wr_state == W_IDLE) && !w_got;
    assign o_bvalid  = (wr_state == W_RESP);
    assign aw_hs     = o_awready && i_awvalid;
    assign w_hs      = o_wready && i_wvalid;

    // Commit on the edge where address and data are both available, whether
    // captured earlier or arriving this cycle.
    assign commit  = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    assign cm_addr = aw_got ? aw_addr_q : i_awaddr;
    assign cm_data = w_got  ? wdata_q   : i_wdata;
    assign cm_strb = w_got  ? wstrb_q   : i_wstrb;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_state  <= W_IDLE;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            o_bresp   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= i_awaddr;
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wdata_q <= i_wdata;
                wstrb_q <= i_wstrb;
            end
            case (wr_state)
                W_IDLE: if (commit) begin
                    o_bresp  <= in_range(cm_addr) ? RESP_OKAY : RESP_SLVERR;
                    wr_state <= W_RESP;
                end
                W_RESP: if (i_bready) begin
                    aw_got   <= 1'b0;
                    w_got    <= 1'b0;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Memory contents survive reset; only in-range commits touch the array.
    always_ff @(posedge clk) begin
        if (commit && in_range(cm_addr)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cm_strb[b]) begin
                    mem[word_idx(cm_addr)][b*8 +: 8] <= cm_data[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- burst beat counters ----------------
    ysyx_201979054_beat_counter #(.BURST_LEN(BURST_LEN)) u_rd_cnt (
        .clk    (clk),
        .arstn  (arstn),
        .i_beat (o_rvalid && i_rready),
        .o_done (o_rd_done)
    );

    ysyx_201979054_beat_counter #(.BURST_LEN(BURST_LEN)) u_wr_cnt (
        .clk    (clk),
        .arstn  (arstn),
        .i_beat (o_bvalid && i_bready),
        .o_done (o_wr_done)
    );

endmodule
